count_seq_ctrl: RTL and testbench
=================================

// Module: count_seq_ctrl
// PURPOSE
//   Next-state and enable generator sitting directly upstream of the per-bit D flip-flop
//   register bank of the synchronous binary counter.
//   - Reads the bank's current state q.
//   - Drives each flip-flop's d and ena.
//   - Owns the run/stop control FSM, the count-rate prescaler and terminal-count detection.
// PARAMETERS
//   WIDTH     4  counter width in bits (number of flip-flops driven); >= 1
//   PRESCALE  3  clock cycles per count step while running; >= 1 (1 = step every cycle)
// PORTS
//   clk      in   1      clock; all state updates on rising edge
//   rst      in   1      synchronous, active-high reset
//   start    in   1      level, sampled each cycle: IDLE -> RUN
//   stop     in   1      level, sampled each cycle: RUN -> IDLE (pause, q held)
//   clear    in   1      level, sampled each cycle: zero counter, go IDLE
//   up_dn    in   1      1 = count up, 0 = count down
//   q        in   WIDTH  current flip-flop bank outputs
//   d        out  WIDTH  next value for each flip-flop
//   ena      out  WIDTH  per-bit flip-flop enable
//   tick     out  1      registered one-cycle count-step strobe
//   tc       out  1      terminal count; one-cycle pulse
//   running  out  1      1 while FSM in RUN
// BEHAVIOUR
//   FSM states: IDLE, RUN, DONE (DONE exists only with TC_STOP_EN).
//   Input priority per cycle: rst > clear > stop > start.
//   - IDLE: start -> RUN.
//   - RUN: stop -> IDLE; start ignored, prescaler not restarted.
//   - any state: clear -> IDLE.
//   Prescaler:
//   - pre_cnt counts 0..PRESCALE-1 only in RUN.
//   - Forced to 0 in IDLE/DONE and on clear, so counting resumes fresh on every start.
//   - tick (registered) = 1 for the cycle after pre_cnt == PRESCALE-1 in RUN.
//   - First tick is PRESCALE cycles after the edge that sampled start.
//   Next value (combinational from q, up_dn):
//   - nxt = q+1 when up_dn=1, q-1 when up_dn=0, modulo 2^WIDTH.
//   - up_dn changes take effect at the next tick.
//   Clear:
//   - clear sampled -> clr_r=1 for exactly one cycle.
//   - During that cycle d=0 and ena=all ones, so the bank loads 0 at the following edge.
//   Outputs:
//   - d = clr_r ? 0 : nxt
//   - ena = clr_r ? {WIDTH{1}} : (tick ? (nxt ^ q) : 0)
//     i.e. only toggling bits are enabled.
//   - tc = tick & ~clr_r & ((up_dn & q == all ones) | (~up_dn & q == 0))
//   - running = (state == RUN)
//   Simultaneous events:
//   - clear with tick: no count step, tc=0.
//   - clear with start: clear wins, FSM ends IDLE.
//   - stop with tick pending: the already-registered tick still applies once.
//   Reset:
//   - state=IDLE, pre_cnt=0, tick=0, clr_r=0.
//   - Therefore ena=0, tc=0, running=0; d follows nxt of q.
//   - The flip-flop bank is reset by its own reset; this block does not drive q to 0.
//   - Reset mid-run aborts immediately; no enable is issued in the reset cycle or the cycle after.
// CONFIGURATION
//   TC_STOP_EN defined:
//   - The tick at terminal count still pulses tc but forces ena=0, so q holds at its end value.
//   - FSM RUN -> DONE. running=0 in DONE.
//   - start and stop are ignored in DONE; only clear (-> IDLE) or rst leaves DONE.
//   TC_STOP_EN undefined:
//   - Counter wraps: ena=nxt^q (all ones on wrap); FSM stays in RUN; DONE is unreachable.
// TESTING  (WIDTH=4, PRESCALE=3, bank of 4 DFFs attached, q starts 0)
//   1. rst held 2 cycles with start=1
//      -> running=0, tick=0, tc=0, ena=0 during reset and the cycle after; q stays 0.
//   2. start pulse
//      -> first tick 3 cycles later with ena=4'b0001, d=1; next tick at q=1 gives ena=4'b0011;
//         q steps 0,1,2,3 every 3 cycles.
//   3. Count up to q=15
//      -> tc=1 on that tick.
//      -> Without macro: ena=4'b1111, d=0, q wraps to 0, running stays 1.
//      -> With TC_STOP_EN: ena=0, q holds 15, running=0, a later start is ignored.
//   4. up_dn=0, start at q=0
//      -> first tick: d=15, ena=4'b1111, tc=1 (without macro q becomes 15).
//   5. clear asserted in the same cycle as start and a pending tick at q=5
//      -> next cycle ena=4'b1111, d=0, tc=0; q becomes 0; running=0.
//   6. stop 1 cycle into a prescale period, then start 4 cycles later
//      -> no tick while IDLE; next tick exactly 3 cycles after start.
//      -> start and stop in the same cycle from IDLE -> FSM stays IDLE.

Source files
------------

// File: rtl/count_seq_ctrl_if.sv
// rtl/count_seq_ctrl_if.sv - control and flip-flop bank signals of the counter sequencer
// master: environment side (drives controls and bank state q, observes d/ena/status)
// slave : count_seq_ctrl side
//   start, stop, clear, up_dn : run control levels and count direction
//   q                         : current flip-flop bank outputs
//   d, ena                    : next value and per-bit enable for the bank
//   tick, tc, running         : count-step strobe, terminal-count pulse, RUN indicator
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             clear;
    logic             up_dn;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] ena;
    logic             tick;
    logic             tc;
    logic             running;

    modport master (
        output start, stop, clear, up_dn, q,
        input  d, ena, tick, tc, running
    );

    modport slave (
        input  start, stop, clear, up_dn, q,
        output d, ena, tick, tc, running
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - next-state/enable generator for a synchronous binary counter bank
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : count_seq_ctrl_if.slave (start/stop/clear/up_dn/q in; d/ena/tick/tc/running out)
// Parameters: WIDTH (bank width), PRESCALE (clock cycles per count step)
// Optional feature: define TC_STOP_EN to stop at terminal count (FSM enters DONE)
module count_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 3
) (
    input  logic              clk,
    input  logic              rst,
    count_seq_ctrl_if.slave   bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

`ifdef TC_STOP_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    pre_cnt;
    logic             tick_r;
    logic             clr_r;
    logic [WIDTH-1:0] nxt;
    logic             term;
    logic             tc_hit;

    assign nxt  = bus.up_dn ? (bus.q + WIDTH'(1)) : (bus.q - WIDTH'(1));
    assign term = bus.up_dn ? (&bus.q) : ~(|bus.q);

    // Gated by rst so a tick already registered before a mid-run reset never leaks out.
    assign tc_hit = tick_r & ~clr_r & term & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pre_cnt <= '0;
            tick_r  <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            clr_r <= bus.clear;
            // A clear arriving with a pending step swallows it; stop does not.
            tick_r <= (state == RUN) && (pre_cnt == PRE_LAST) && !bus.clear;
            if ((state == RUN) && !bus.clear && (pre_cnt != PRE_LAST))
                pre_cnt <= pre_cnt + PW'(1);
            else
                pre_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.d     = clr_r ? '0 : nxt;
        bus.ena   = '0;

        if (!rst) begin
            if (clr_r)
                bus.ena = '1;
            else if (tick_r) begin
`ifdef TC_STOP_EN
                bus.ena = term ? '0 : (nxt ^ bus.q);
`else
                bus.ena = nxt ^ bus.q;
`endif
            end
        end

        case (state)
            IDLE: if (!bus.stop && bus.start) state_nxt = RUN;
            RUN: begin
                if (bus.stop)
                    state_nxt = IDLE;
`ifdef TC_STOP_EN
                else if (tc_hit)
                    state_nxt = DONE;
`endif
            end
`ifdef TC_STOP_EN
            DONE: state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase

        if (bus.clear)
            state_nxt = IDLE;
    end

    assign bus.tick    = tick_r;
    assign bus.tc      = tc_hit;
    assign bus.running = (state == RUN);
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - self-checking bench for count_seq_ctrl with an attached 4-bit DFF bank
module tb_count_seq_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] bank;

    count_seq_ctrl_if #(.WIDTH(W)) bus();

    count_seq_ctrl #(.WIDTH(W), .PRESCALE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Flip-flop bank: per-bit enabled D flip-flops with their own reset.
    assign bus.q = bank;
    always @(posedge clk) begin
        if (rst) bank <= '0;
        else     bank <= (bank & ~bus.ena) | (bus.d & bus.ena);
    end

    // in = {rst, start, stop, clear, up_dn}; flg = {running, tick, tc}
    typedef struct {
        logic [4:0] in;
        logic [2:0] flg;
        logic [3:0] ena;
        logic [3:0] d;
        logic [3:0] q;
    } vec_t;

    vec_t sb[$];
    vec_t mon_e;
    vec_t tbl[14];
    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;

    function automatic vec_t mk(input logic [4:0] in, input logic [2:0] flg,
                                input logic [3:0] ena, input logic [3:0] d, input logic [3:0] q);
        vec_t v;
        v.in = in; v.flg = flg; v.ena = ena; v.d = d; v.q = q;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d actual %0h required %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst       = v.in[4];
        bus.start = v.in[3];
        bus.stop  = v.in[2];
        bus.clear = v.in[1];
        bus.up_dn = v.in[0];
        sb.push_back(v);
    endtask

    task automatic s(input logic [4:0] in, input logic [2:0] flg,
                     input logic [3:0] ena, input logic [3:0] d, input logic [3:0] q);
        apply(mk(in, flg, ena, d, q));
    endtask

    // One counting-up prescale period from q=v: two quiet cycles then the step.
    task automatic period(input int v);
        logic [3:0] qv;
        logic [3:0] nv;
        logic [3:0] te;
        qv = 4'(v);
        nv = qv + 4'd1;
        te = qv ^ nv;
`ifdef TC_STOP_EN
        if (qv == 4'hF) te = 4'h0;
`endif
        s(5'b00001, 3'b100, 4'h0, nv, qv);
        s(5'b00001, 3'b100, 4'h0, nv, qv);
        s(5'b00001, {2'b11, qv == 4'hF}, te, nv, qv);
    endtask

    // Scoreboard consumer: outputs sampled mid-cycle, well clear of the rising edge.
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("running", vidx, {3'b000, bus.running}, {3'b000, mon_e.flg[2]});
            chk("tick",    vidx, {3'b000, bus.tick},    {3'b000, mon_e.flg[1]});
            chk("tc",      vidx, {3'b000, bus.tc},      {3'b000, mon_e.flg[0]});
            chk("ena",     vidx, bus.ena, mon_e.ena);
            chk("d",       vidx, bus.d,   mon_e.d);
            chk("q",       vidx, bank,    mon_e.q);
            vidx++;
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
        bus.up_dn = 1'b1;
        rst       = 1'b1;

        // Reset held two cycles with start high, then a start pulse and the first steps.
        tbl[0]  = mk(5'b11001, 3'b000, 4'h0, 4'h1, 4'h0);
        tbl[1]  = mk(5'b11001, 3'b000, 4'h0, 4'h1, 4'h0);
        tbl[2]  = mk(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);
        tbl[3]  = mk(5'b01001, 3'b000, 4'h0, 4'h1, 4'h0);
        tbl[4]  = mk(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        tbl[5]  = mk(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        tbl[6]  = mk(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        tbl[7]  = mk(5'b00001, 3'b110, 4'h1, 4'h1, 4'h0);
        tbl[8]  = mk(5'b00001, 3'b100, 4'h0, 4'h2, 4'h1);
        tbl[9]  = mk(5'b00001, 3'b100, 4'h0, 4'h2, 4'h1);
        tbl[10] = mk(5'b00001, 3'b110, 4'h3, 4'h2, 4'h1);
        tbl[11] = mk(5'b00001, 3'b100, 4'h0, 4'h3, 4'h2);
        tbl[12] = mk(5'b00001, 3'b100, 4'h0, 4'h3, 4'h2);
        tbl[13] = mk(5'b00001, 3'b110, 4'h1, 4'h3, 4'h2);

        @(posedge clk);
        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // Count up through terminal count.
        for (int v = 3; v <= 15; v++) period(v);
`ifdef TC_STOP_EN
        s(5'b00001, 3'b000, 4'h0, 4'h0, 4'hF);
        s(5'b01001, 3'b000, 4'h0, 4'h0, 4'hF);
        s(5'b00101, 3'b000, 4'h0, 4'h0, 4'hF);
        s(5'b00011, 3'b000, 4'h0, 4'h0, 4'hF);
        s(5'b00001, 3'b000, 4'hF, 4'h0, 4'hF);
`else
        s(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00101, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b010, 4'h1, 4'h1, 4'h0);
        s(5'b00011, 3'b000, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b000, 4'hF, 4'h0, 4'h1);
`endif

        // Count down from 0: terminal count on the first step.
        s(5'b01000, 3'b000, 4'h0, 4'hF, 4'h0);
        s(5'b00000, 3'b100, 4'h0, 4'hF, 4'h0);
        s(5'b00000, 3'b100, 4'h0, 4'hF, 4'h0);
        s(5'b00000, 3'b100, 4'h0, 4'hF, 4'h0);
`ifdef TC_STOP_EN
        s(5'b00000, 3'b111, 4'h0, 4'hF, 4'h0);
        s(5'b00010, 3'b000, 4'h0, 4'hF, 4'h0);
        s(5'b00001, 3'b000, 4'hF, 4'h0, 4'h0);
`else
        s(5'b00000, 3'b111, 4'hF, 4'hF, 4'h0);
        s(5'b00010, 3'b100, 4'h0, 4'hE, 4'hF);
        s(5'b00001, 3'b000, 4'hF, 4'h0, 4'hF);
`endif

        // Clear together with start and a pending step at q=5.
        s(5'b01001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        for (int v = 0; v < 5; v++) period(v);
        s(5'b00001, 3'b100, 4'h0, 4'h6, 4'h5);
        s(5'b01011, 3'b100, 4'h0, 4'h6, 4'h5);
        s(5'b00001, 3'b000, 4'hF, 4'h0, 4'h5);
        s(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);

        // Stop one cycle into a period, restart four cycles later.
        s(5'b01001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00101, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b01001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b100, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b110, 4'h1, 4'h1, 4'h0);
        s(5'b00101, 3'b100, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b000, 4'h0, 4'h2, 4'h1);
        // start and stop together from IDLE: stays IDLE.
        s(5'b01101, 3'b000, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b000, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b000, 4'h0, 4'h2, 4'h1);

        // Reset landing on a tick cycle: no enable, run aborted.
        s(5'b01001, 3'b000, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b100, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b100, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b100, 4'h0, 4'h2, 4'h1);
        s(5'b10001, 3'b110, 4'h0, 4'h2, 4'h1);
        s(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);
        s(5'b00001, 3'b000, 4'h0, 4'h1, 4'h0);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
